seg_scan_disp: RTL and testbench
================================

// Module: seg_scan_disp
// PURPOSE
//  Downstream display stage of the 4-bit calculator. Captures the {high,low} result
//  nibbles and the function code from the selected operation unit (min, max, add, ...).
//  Drives a 4-digit multiplexed common-anode 7-segment display:
//  digit3=func code, digit2=blank, digit1=high nibble (hex), digit0=low nibble (hex).
// PARAMETERS
//  SCAN_DIV  50000  clock cycles per digit slot; minimum 2 (1 ms at 50 MHz)
// PORTS
//  clk        in   1  system clock, rising edge
//  rst_n      in   1  reset, asynchronous, active-low
//  res_valid  in   1  1-cycle strobe: res_high/res_low/func_code valid this cycle
//  res_high   in   4  result high nibble
//  res_low    in   4  result low nibble
//  func_code  in   3  selected operation code, shown as hex 0-7
//  disp_clr   in   1  synchronous clear: blank all digits until next res_valid
//  seg        out  8  segments {dp,g,f,e,d,c,b,a}, active-low, registered
//  an         out  4  digit enables, active-low one-hot, registered
//  disp_vld   out  1  1 = a captured result is on display
// BEHAVIOUR
//  - Reset (async, rst_n=0, no clock needed):
//      an=4'b1111, seg=8'hFF, disp_vld=0, cnt=0, idx=0, latched data=0.
//  - Slot counter cnt: 0..SCAN_DIV-1, wraps.
//      At an edge with cnt==SCAN_DIV-1: cnt<=0, idx<=idx+1 (2-bit, 3->0 wrap).
//  - an update on each edge:
//      an <= (cnt==SCAN_DIV-1) ? 4'b1111 : ~(4'b0001<<idx).
//      Result: 1 blanking cycle per slot (anti-ghosting), digit lit SCAN_DIV-1 cycles.
//  - Start-up: first edge after reset release gives an=4'b1110.
//  - seg update on each edge:
//      seg <= 8'hFF when the an value being loaded is 4'b1111, or disp_vld=0, or idx==2.
//      Otherwise seg <= hex font of: low (idx0), high (idx1), {1'b0,func_code} (idx3).
//      dp is always off.
//  - Hex font (active-low): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8,
//      8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.
//  - Capture: res_valid=1 at edge E -> data regs loaded and disp_vld<=1 at E.
//      seg reflects the new data from edge E+1 onward, with no wait for a slot boundary.
//      The scan timing (cnt, idx, an) is unaffected by capture.
//  - disp_clr=1 and res_valid=0 at edge E -> disp_vld<=0 at E; data regs hold their values.
//  - disp_clr and res_valid high in the same cycle: res_valid wins (capture, disp_vld=1).
//  - Back-to-back res_valid: every strobe captures; the last one wins.
//  - Mid-operation async reset: outputs go to reset values immediately.
//      After release, scanning restarts at idx 0 and the display is blank (disp_vld=0).
// STRUCTURE
//  - Shared package calc_pkg:
//      SEG_BLANK=8'hFF, AN_OFF=4'hF, 16-entry hex font constants, DIGIT_W=2,
//      digit position constants (DIG_LOW=0, DIG_HIGH=1, DIG_GAP=2, DIG_FUNC=3).
//  - Sub-module seg_hex_dec: combinational 4-bit -> 8-bit font lookup, one instance,
//      fed by an idx-selected nibble mux.
//  - Top level holds: slot counter, digit index, data/valid registers, output registers.
// TESTING (bench uses SCAN_DIV=4)
//  1. Reset: hold rst_n=0 -> an=1111, seg=FF, disp_vld=0.
//     Release -> an = 1110 x3, 1111, 1101 x3, 1111, 1011 x3, 1111, 0111 x3, 1111;
//     seg=FF throughout.
//  2. res_valid pulse with high=0, low=3, func=4 -> disp_vld=1.
//     Per slot: digit0 seg=B0, digit1 seg=C0, digit2 seg=FF, digit3 seg=99.
//  3. disp_clr pulse -> disp_vld=0 next edge, seg=FF on every digit.
//     Then clr+valid together with high=A, low=F -> disp_vld=1, digit1=88, digit0=8E.
//  4. Run 20 slots -> idx wraps 3->0 cleanly.
//     Exactly one an=1111 cycle per slot; never two an bits low at once.
//  5. Async reset asserted at cnt=2, idx=2 with no clock edge -> an=1111, seg=FF
//     immediately. After release, the first lit digit is idx0 (an=1110).
//  6. While digit0 lit (low=3, seg=B0), res_valid with low=7 ->
//     seg=F8 one edge later, an unchanged, slot length unchanged.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg -- constants shared by the calculator display path.
//   SEG_BLANK / AN_OFF : all segments dark / all digits disabled (active-low)
//   HEX_FONT           : 16-entry active-low font, {dp,g,f,e,d,c,b,a}, dp off
//   digit_t / DIG_*    : scan position of each display digit
package calc_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [3:0] AN_OFF    = 4'hF;

    // Index n holds the glyph for hex digit n (entry 0 is the rightmost literal).
    localparam logic [15:0][7:0] HEX_FONT = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    localparam int DIGIT_W = 2;
    typedef logic [DIGIT_W-1:0] digit_t;

    localparam digit_t DIG_LOW  = 2'd0;
    localparam digit_t DIG_HIGH = 2'd1;
    localparam digit_t DIG_GAP  = 2'd2;
    localparam digit_t DIG_FUNC = 2'd3;

endpackage

// File: rtl/seg_hex_dec.sv
// seg_hex_dec -- combinational hex-digit to 7-segment glyph lookup.
//   nibble_i : 4-bit value to display
//   seg_o    : active-low segments {dp,g,f,e,d,c,b,a}, dp always off
module seg_hex_dec
    import calc_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [7:0] seg_o
);

    assign seg_o = HEX_FONT[nibble_i];

endmodule

// File: rtl/seg_scan_disp.sv
// seg_scan_disp -- 4-digit multiplexed common-anode display driver for the
// calculator result. digit3 = function code, digit2 = blank, digit1 = high
// nibble, digit0 = low nibble.
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   res_valid  : one-cycle strobe qualifying res_high/res_low/func_code
//   res_high   : result high nibble
//   res_low    : result low nibble
//   func_code  : operation code, shown as hex 0-7
//   disp_clr   : blank the display until the next res_valid
//   seg        : active-low segments {dp,g,f,e,d,c,b,a}, registered
//   an         : active-low one-hot digit enables, registered
//   disp_vld   : a captured result is on display
module seg_scan_disp
    import calc_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       res_valid,
    input  logic [3:0] res_high,
    input  logic [3:0] res_low,
    input  logic [2:0] func_code,
    input  logic       disp_clr,
    output logic [7:0] seg,
    output logic [3:0] an,
    output logic       disp_vld
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    digit_t           idx_q, idx_d;
    logic [3:0]       an_q, an_d;
    logic [7:0]       seg_q, seg_d;
    logic             vld_q, vld_d;
    logic [3:0]       hi_q, hi_d;
    logic [3:0]       lo_q, lo_d;
    logic [2:0]       func_q, func_d;

    logic             slot_end;
    logic [3:0]       lit_n;
    logic [3:0]       nib_sel;
    logic [7:0]       font_w;

    // Active-low enable pattern for the digit currently addressed by idx_q.
    for (genvar gi = 0; gi < 4; gi++) begin : g_an_dec
        assign lit_n[gi] = (idx_q != digit_t'(gi));
    end

    always_comb begin
        nib_sel = 4'h0;
        case (idx_q)
            DIG_LOW:  nib_sel = lo_q;
            DIG_HIGH: nib_sel = hi_q;
            DIG_FUNC: nib_sel = {1'b0, func_q};
            default:  nib_sel = 4'h0;
        endcase
    end

    seg_hex_dec u_hex_dec (
        .nibble_i (nib_sel),
        .seg_o    (font_w)
    );

    always_comb begin
        slot_end = (cnt_q == CNT_LAST);
        cnt_d    = slot_end ? '0 : cnt_q + CNT_W'(1);
        idx_d    = slot_end ? idx_q + digit_t'(1) : idx_q;

        // Last cycle of each slot is dark so the next digit never shows a
        // stale glyph while the anodes switch.
        an_d = slot_end ? AN_OFF : lit_n;

        // Glyph follows the registered data, so a capture shows up on the
        // very next edge without waiting for a slot boundary.
        if (an_d == AN_OFF || !vld_q || idx_q == DIG_GAP) begin
            seg_d = SEG_BLANK;
        end else begin
            seg_d = font_w;
        end

        hi_d   = hi_q;
        lo_d   = lo_q;
        func_d = func_q;
        vld_d  = vld_q;
        if (res_valid) begin
            hi_d   = res_high;
            lo_d   = res_low;
            func_d = func_code;
            vld_d  = 1'b1;
        end else if (disp_clr) begin
            vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            idx_q  <= DIG_LOW;
            an_q   <= AN_OFF;
            seg_q  <= SEG_BLANK;
            vld_q  <= 1'b0;
            hi_q   <= 4'h0;
            lo_q   <= 4'h0;
            func_q <= 3'h0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            vld_q  <= vld_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            func_q <= func_d;
        end
    end

    assign seg      = seg_q;
    assign an       = an_q;
    assign disp_vld = vld_q;

endmodule

// File: tb/tb_seg_scan_disp.sv
module tb_seg_scan_disp;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       res_valid = 1'b0;
    logic       disp_clr = 1'b0;
    logic [3:0] res_high = 4'h0;
    logic [3:0] res_low = 4'h0;
    logic [2:0] func_code = 3'h0;
    logic [7:0] seg;
    logic [3:0] an;
    logic       disp_vld;

    int checks = 0;
    int failures = 0;

    // Reference model: elapsed edges since reset release plus the shown data.
    int         k;
    bit         m_vld;
    logic [3:0] m_hi, m_lo;
    logic [2:0] m_fn;
    logic [3:0] exp_an;
    logic [7:0] exp_seg;
    bit         exp_vld;

    seg_scan_disp #(.SCAN_DIV(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .res_valid (res_valid),
        .res_high  (res_high),
        .res_low   (res_low),
        .func_code (func_code),
        .disp_clr  (disp_clr),
        .seg       (seg),
        .an        (an),
        .disp_vld  (disp_vld)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] font_ref(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
            4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
            4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
            4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
        endcase
    endfunction

    // Drive one cycle of inputs, predict the outputs after the next edge.
    task automatic tick(input bit v, input bit c, input logic [3:0] h,
                        input logic [3:0] l, input logic [2:0] f);
        int slot_pos, digit;
        logic [3:0] nib;
        @(negedge clk);
        res_valid = v; disp_clr = c; res_high = h; res_low = l; func_code = f;
        slot_pos = k % D;
        digit    = (k / D) % 4;
        exp_an   = (slot_pos == D - 1) ? 4'hF : ~(4'b0001 << digit);
        nib      = (digit == 0) ? m_lo : (digit == 1) ? m_hi : {1'b0, m_fn};
        exp_seg  = (exp_an == 4'hF || !m_vld || digit == 2) ? 8'hFF : font_ref(nib);
        exp_vld  = v ? 1'b1 : (c ? 1'b0 : m_vld);
        @(posedge clk);
        #1;
        k++;
        m_vld = exp_vld;
        if (v) begin m_hi = h; m_lo = l; m_fn = f; end
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 4'h0, 4'h0, 3'h0);
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        res_valid = 1'b0; disp_clr = 1'b0;
        k = 0; m_vld = 1'b0; m_hi = 4'h0; m_lo = 4'h0; m_fn = 3'h0;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [3:0] an_tab [16] = '{4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD, 4'hF,
                                    4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7, 4'hF};
        assert_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({an, seg, disp_vld} !== {4'hF, 8'hFF, 1'b0}) begin
            failures++;
            $display("FAIL reset_hold an=%h seg=%h vld=%b want an=f seg=ff vld=0", an, seg, disp_vld);
        end
        release_reset();
        for (int i = 0; i < 16; i++) begin
            idle();
            checks++;
            if ({an, seg, disp_vld} !== {an_tab[i], 8'hFF, 1'b0}) begin
                failures++;
                $display("FAIL startup_scan[%0d] an=%h seg=%h vld=%b want an=%h seg=ff vld=0",
                         i, an, seg, disp_vld, an_tab[i]);
            end
        end
    endtask

    task automatic test_capture();
        tick(1'b1, 1'b0, 4'h0, 4'h3, 3'h4);
        checks++;
        if (disp_vld !== 1'b1) begin
            failures++;
            $display("FAIL capture_vld got=%b want=1", disp_vld);
        end
        for (int i = 0; i < 16; i++) begin
            idle();
            checks++;
            if ({an, seg, disp_vld} !== {exp_an, exp_seg, exp_vld}) begin
                failures++;
                $display("FAIL capture_scan[%0d] an=%h seg=%h vld=%b want an=%h seg=%h vld=%b",
                         i, an, seg, disp_vld, exp_an, exp_seg, exp_vld);
            end
        end
    endtask

    task automatic test_clear();
        tick(1'b0, 1'b1, 4'h0, 4'h0, 3'h0);
        checks++;
        if (disp_vld !== 1'b0) begin
            failures++;
            $display("FAIL clear_vld got=%b want=0", disp_vld);
        end
        for (int i = 0; i < 8; i++) begin
            idle();
            checks++;
            if ({an, seg, disp_vld} !== {exp_an, 8'hFF, 1'b0}) begin
                failures++;
                $display("FAIL clear_blank[%0d] an=%h seg=%h vld=%b want an=%h seg=ff vld=0",
                         i, an, seg, disp_vld, exp_an);
            end
        end
        tick(1'b1, 1'b1, 4'hA, 4'hF, 3'($urandom_range(0, 7)));
        checks++;
        if (disp_vld !== 1'b1) begin
            failures++;
            $display("FAIL clr_and_valid_vld got=%b want=1", disp_vld);
        end
        for (int i = 0; i < 16; i++) begin
            idle();
            checks++;
            if ({an, seg, disp_vld} !== {exp_an, exp_seg, exp_vld}) begin
                failures++;
                $display("FAIL clr_and_valid_scan[%0d] an=%h seg=%h vld=%b want an=%h seg=%h vld=%b",
                         i, an, seg, disp_vld, exp_an, exp_seg, exp_vld);
            end
        end
    endtask

    task automatic test_scan_wrap();
        int blanks = 0;
        for (int i = 0; i < 20 * D; i++) begin
            tick(($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
                 4'($urandom), 4'($urandom), 3'($urandom));
            if (an == 4'hF) blanks++;
            checks++;
            if ({an, seg, disp_vld} !== {exp_an, exp_seg, exp_vld} || $countones(~an) > 1) begin
                failures++;
                $display("FAIL wrap_scan[%0d] an=%h seg=%h vld=%b want an=%h seg=%h vld=%b",
                         i, an, seg, disp_vld, exp_an, exp_seg, exp_vld);
            end
        end
        checks++;
        if (blanks != 20) begin
            failures++;
            $display("FAIL wrap_blank_count got=%0d want=20", blanks);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, bit'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 3'($urandom));
            checks++;
            if ({an, seg, disp_vld} !== {exp_an, exp_seg, exp_vld}) begin
                failures++;
                $display("FAIL b2b_capture[%0d] an=%h seg=%h vld=%b want an=%h seg=%h vld=%b",
                         i, an, seg, disp_vld, exp_an, exp_seg, exp_vld);
            end
        end
        for (int i = 0; i < 16; i++) begin
            idle();
            checks++;
            if ({an, seg, disp_vld} !== {exp_an, exp_seg, exp_vld}) begin
                failures++;
                $display("FAIL b2b_last_wins[%0d] an=%h seg=%h vld=%b want an=%h seg=%h vld=%b",
                         i, an, seg, disp_vld, exp_an, exp_seg, exp_vld);
            end
        end
    endtask

    task automatic test_async_reset();
        assert_reset();
        release_reset();
        tick(1'b1, 1'b0, 4'($urandom), 4'($urandom), 3'($urandom));
        repeat (9) idle();
        // Ten edges in: slot counter at 2, digit 2 is lit.
        checks++;
        if (an !== 4'hB) begin
            failures++;
            $display("FAIL pre_async_an got=%h want=b", an);
        end
        assert_reset();
        #1;
        checks++;
        if ({an, seg, disp_vld} !== {4'hF, 8'hFF, 1'b0}) begin
            failures++;
            $display("FAIL async_reset an=%h seg=%h vld=%b want an=f seg=ff vld=0", an, seg, disp_vld);
        end
        release_reset();
        idle();
        checks++;
        if ({an, seg, disp_vld} !== {4'hE, 8'hFF, 1'b0}) begin
            failures++;
            $display("FAIL async_restart an=%h seg=%h vld=%b want an=e seg=ff vld=0", an, seg, disp_vld);
        end
    endtask

    task automatic test_midslot_update();
        logic [3:0] h;
        logic [2:0] f;
        logic [3:0] an_want [4] = '{4'hE, 4'hE, 4'hE, 4'hF};
        logic [7:0] seg_want [4] = '{8'hB0, 8'hB0, 8'hF8, 8'hFF};
        h = 4'($urandom);
        f = 3'($urandom);
        assert_reset();
        release_reset();
        tick(1'b1, 1'b0, h, 4'h3, f);
        while (k % (4 * D) != 0) idle();
        for (int i = 0; i < 4; i++) begin
            if (i == 1) tick(1'b1, 1'b0, h, 4'h7, f);
            else idle();
            checks++;
            if ({an, seg} !== {an_want[i], seg_want[i]} || {an, seg} !== {exp_an, exp_seg}) begin
                failures++;
                $display("FAIL midslot[%0d] an=%h seg=%h want an=%h seg=%h",
                         i, an, seg, an_want[i], seg_want[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_clear();
        test_scan_wrap();
        test_back_to_back();
        test_async_reset();
        test_midslot_update();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
